freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Measures the frequency of an asynchronous square-wave input in the system clock domain by counting its rising edges over a fixed gate window of clk cycles.
- Lets the board read back PLL outputs (prescaled toggles of CLKOUTx) and check them against the PLL configuration.
- The result is a raw edge count per gate window, intended for the hex display path and the LEDs.

Parameters:
- GATE_CYCLES, 100_000_000: gate window length in clk cycles. At 100 MHz this is 1 s, so the result reads directly in Hz. Minimum 2.
- CNT_W, 32: width of the edge counter and of freq_o.
- SYNC_STAGES, 2: number of synchronizer flops on sig_i. Minimum 2.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  synchronous, active-high reset.
- en  in  1  block enable. Deasserting it aborts a measurement in progress.
- start  in  1  single-cycle request to start one measurement.
- sig_i  in  1  asynchronous signal under measurement.
- freq_o  out  CNT_W  edge count from the last completed window. Held until the next completion.
- valid_o  out  1  one-cycle pulse when freq_o updates.
- busy_o  out  1  high while a gate window is open.
- ovf_o  out  1  sticky flag: the edge count saturated in the last completed window.

Behaviour:
- Reset (rst=1 at a clk edge):
  - freq_o=0, valid_o=0, busy_o=0, ovf_o=0.
  - Synchronizer flops and previous-sample flop cleared to 0.
  - State goes to IDLE.
- Input conditioning:
  - sig_i passes through a SYNC_STAGES flop chain, then one more flop (prev).
  - rise = sync_out & ~prev.
  - prev updates every cycle in every state.
  - Edges are counted only in MEASURE.
  - Counting is exact for sig_i below f_clk/4 with both phases at least 2 clk periods. Faster input is undefined.
- FSM states: IDLE, MEASURE, REPORT.
  - IDLE: busy_o=0. If start & en: clear gate_cnt and edge_cnt, clear ovf_o, go to MEASURE. Otherwise stay.
  - MEASURE: busy_o=1. gate_cnt increments every cycle. edge_cnt increments on rise, saturating at all-ones; on saturation, set the internal ovf flag.
    - If en=0: go to IDLE the next cycle. No valid_o. freq_o and ovf_o keep their old values.
    - When gate_cnt==GATE_CYCLES-1: go to REPORT. The rise on this cycle is counted.
    - The window is exactly GATE_CYCLES cycles.
  - REPORT: lasts one cycle. freq_o <= final edge_cnt, ovf_o <= ovf flag, and valid_o=1 during this cycle. busy_o=0. Go to IDLE.
- start while in MEASURE or REPORT is ignored.
- Latency: with start sampled at edge N, the window covers edges N+1..N+GATE_CYCLES, and valid_o is high in the cycle after edge N+GATE_CYCLES.
- Widths:
  - gate_cnt width is $clog2(GATE_CYCLES).
  - edge_cnt is CNT_W bits and never wraps.
  - Frequency = freq_o * f_clk / GATE_CYCLES.
- rst asserted mid-measurement takes priority over every other event: state returns to IDLE, and all outputs take their reset values on the next edge.

Optional Feature:
- Macro: FREQ_METER_CONT_EN.
- When defined, REPORT goes directly to MEASURE if en=1, clearing both counters. The meter runs continuously with one valid_o every GATE_CYCLES+1 cycles, and start is not required after the first run.
  - In this mode, en=1 in IDLE also starts a measurement without start.
- When undefined, the block is one-shot: each measurement needs a start pulse, and REPORT always returns to IDLE.

Decomposition:
- Package freq_meter_pkg:
  - State enum typedef fm_state_t {IDLE, MEASURE, REPORT}.
  - Default constants FM_GATE_1S=100_000_000 and FM_CNT_W=32.
- One sub-module: edge_sync_det.
  - SYNC_STAGES flop chain plus the prev flop.
  - Outputs rise.
  - Reusable for switch inputs.

Test Plan (GATE_CYCLES=100 unless noted):
1. Reset: hold rst=1 for 3 cycles with sig_i toggling. Require freq_o=0, valid_o=0, busy_o=0, ovf_o=0.
2. sig_i period 10 clk, start pulse. Require busy_o high for exactly 100 cycles, valid_o high exactly 101 cycles after the start edge, freq_o=10, ovf_o=0.
3. sig_i held high from reset, start. Require freq_o=0 and a valid_o pulse.
4. After scenario 2, start again, then drop en at window cycle 50. Require busy_o=0 next cycle, no valid_o, freq_o still 10.
5. CNT_W=4, sig_i period 4 clk (25 edges). Require freq_o=15 and ovf_o=1. A following start with sig_i period 20 must give freq_o=5 and ovf_o=0.
6. FREQ_METER_CONT_EN defined, en=1, sig_i period 5. Require valid_o every 101 cycles with freq_o=20 each time. Drop en: no further valid_o.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the frequency meter.
package freq_meter_pkg;

  // Measurement sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } fm_state_t;

  // One-second gate at a 100 MHz system clock, so results read in Hz.
  localparam int FM_GATE_1S = 100_000_000;
  localparam int FM_CNT_W   = 32;

endpackage

// File: rtl/edge_sync_det.sv
// Synchronizes an asynchronous input into clk and flags its rising edges.
// The chain output and the prev flop are both flops, so rise is glitch-free.
module edge_sync_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Synchronizer chain plus one extra stage holding the previous sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed window of
// GATE_CYCLES clk cycles and reports the raw count.
// Build option: define FREQ_METER_CONT_EN for back-to-back measurements
// while en is high; otherwise each measurement needs a start pulse.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = FM_GATE_1S,
  parameter int CNT_W       = FM_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic             sig_i,
  output logic [CNT_W-1:0] freq_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             ovf_o
);

  localparam int GATE_W = $clog2(GATE_CYCLES);

`ifdef FREQ_METER_CONT_EN
  localparam bit CONT_MODE = 1'b1;
`else
  localparam bit CONT_MODE = 1'b0;
`endif

  fm_state_t          state_r, state_nxt_s;
  logic [GATE_W-1:0]  gate_cnt_r, gate_nxt_s;
  logic [CNT_W-1:0]   edge_cnt_r, edge_nxt_s, edge_inc_s;
  logic               ovf_r, ovf_nxt_s, ovf_inc_s;
  logic               ovf_clr_s;
  logic               run_req_s;
  logic               rise_s;
  logic [CNT_W-1:0]   freq_r;
  logic               valid_r, busy_r, ovf_o_r;

  edge_sync_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (sig_i),
    .rise (rise_s)
  );

  // In continuous mode en alone launches a window; otherwise start is needed.
  assign run_req_s = CONT_MODE ? en : (start & en);

  // Saturating edge increment; a rise that cannot be counted marks overflow.
  always_comb begin
    edge_inc_s = edge_cnt_r;
    ovf_inc_s  = ovf_r;
    if (rise_s && (edge_cnt_r == {CNT_W{1'b1}})) begin
      ovf_inc_s = 1'b1;
    end else if (rise_s) begin
      edge_inc_s = edge_cnt_r + CNT_W'(1'b1);
    end else begin
      edge_inc_s = edge_cnt_r;
    end
  end

  // Next-state and counter update logic for the gate window sequencer.
  always_comb begin
    state_nxt_s = state_r;
    gate_nxt_s  = gate_cnt_r;
    edge_nxt_s  = edge_cnt_r;
    ovf_nxt_s   = ovf_r;
    ovf_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (run_req_s) begin
          state_nxt_s = MEASURE;
          gate_nxt_s  = {GATE_W{1'b0}};
          edge_nxt_s  = {CNT_W{1'b0}};
          ovf_nxt_s   = 1'b0;
          ovf_clr_s   = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEASURE: begin
        gate_nxt_s = gate_cnt_r + GATE_W'(1'b1);
        edge_nxt_s = edge_inc_s;
        ovf_nxt_s  = ovf_inc_s;
        if (!en) begin
          state_nxt_s = IDLE;
        end else if (gate_cnt_r == GATE_W'(GATE_CYCLES - 1)) begin
          state_nxt_s = REPORT;
        end else begin
          state_nxt_s = MEASURE;
        end
      end
      REPORT: begin
        if (CONT_MODE && en) begin
          state_nxt_s = MEASURE;
          gate_nxt_s  = {GATE_W{1'b0}};
          edge_nxt_s  = {CNT_W{1'b0}};
          ovf_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; results latch on entry to REPORT
  // so that valid_o, freq_o and ovf_o all change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      gate_cnt_r <= {GATE_W{1'b0}};
      edge_cnt_r <= {CNT_W{1'b0}};
      ovf_r      <= 1'b0;
      freq_r     <= {CNT_W{1'b0}};
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      ovf_o_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      gate_cnt_r <= gate_nxt_s;
      edge_cnt_r <= edge_nxt_s;
      ovf_r      <= ovf_nxt_s;
      busy_r     <= (state_nxt_s == MEASURE);
      valid_r    <= (state_nxt_s == REPORT);
      if (state_nxt_s == REPORT) begin
        freq_r  <= edge_nxt_s;
        ovf_o_r <= ovf_nxt_s;
      end else if (ovf_clr_s) begin
        ovf_o_r <= 1'b0;
      end else begin
        ovf_o_r <= ovf_o_r;
      end
    end
  end

  assign freq_o  = freq_r;
  assign valid_o = valid_r;
  assign busy_o  = busy_r;
  assign ovf_o   = ovf_o_r;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: a 32-bit and a 4-bit instance with a
// 100-cycle gate. Expected {ovf,freq} results are queued when a measurement
// is launched and compared whenever the DUT pulses valid_o.
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int G = 100;

  logic        clk, rst, en, start, start4, sig_i;
  logic [31:0] freq_o;
  logic [3:0]  freq4_o;
  logic        valid_o, busy_o, ovf_o;
  logic        valid4_o, busy4_o, ovf4_o;

  int n_vec  = 0;
  int n_fail = 0;
  int sig_per = 0;
  logic sig_lvl = 1'b0;
  int cyc = 0;

  logic [32:0] sb_q[$];
  logic [32:0] sb4_q[$];

  freq_meter #(.GATE_CYCLES(G), .CNT_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .sig_i(sig_i),
    .freq_o(freq_o), .valid_o(valid_o), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .start(start4), .sig_i(sig_i),
    .freq_o(freq4_o), .valid_o(valid4_o), .busy_o(busy4_o), .ovf_o(ovf4_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter for interval measurements.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Square-wave source: period sig_per clk cycles, or constant sig_lvl if 0.
  initial begin
    int ph;
    ph = 0;
    sig_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (sig_per == 0) begin
        sig_i = sig_lvl;
      end else begin
        if (ph >= sig_per - 1) ph = 0;
        else ph++;
        sig_i = (ph < sig_per / 2);
      end
    end
  end

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (valid_o) begin
      if (sb_q.size() == 0) chk("unexp_valid", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("sb_freq", freq_o, e[31:0]);
        chk("sb_ovf", {31'd0, ovf_o}, {31'd0, e[32]});
      end
    end
    if (valid4_o) begin
      if (sb4_q.size() == 0) chk("unexp_valid4", 32'd1, 32'd0);
      else begin
        e = sb4_q.pop_front();
        chk("sb4_freq", {28'd0, freq4_o}, e[31:0]);
        chk("sb4_ovf", {31'd0, ovf4_o}, {31'd0, e[32]});
      end
    end
  end

  task automatic pulse_start(input bit four);
    @(posedge clk);
    #1;
    if (four) start4 = 1'b1;
    else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (sb_q.size() != 0 || sb4_q.size() != 0); i++)
      @(negedge clk);
    chk("sb_drain", sb_q.size() + sb4_q.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_freq"}, freq_o, 32'd0);
    chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf_o}, 32'd0);
    chk({tag, "_freq4"}, {28'd0, freq4_o}, 32'd0);
  endtask

  // Expected saturated count for a given period and counter width.
  function automatic logic [32:0] model(input int per, input int w);
    longint edges, maxv;
    edges = (per == 0) ? 0 : G / per;
    maxv  = (longint'(1) << w) - 1;
    if (edges > maxv) return {1'b1, 32'(maxv)};
    else return {1'b0, 32'(edges)};
  endfunction

  initial begin
    int busy_cnt, valid_at, nval, last_cyc;
    rst = 1'b1; en = 1'b0; start = 1'b0; start4 = 1'b0;
    sig_per = 6;

    // 1: reset with the input toggling.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("t1");
    #1 rst = 1'b0;

`ifndef FREQ_METER_CONT_EN
    en = 1'b1;

    // 3: input held high, no edges in the window.
    sig_per = 0; sig_lvl = 1'b1;
    repeat (10) @(posedge clk);
    sb_q.push_back(model(0, 32));
    pulse_start(1'b0);
    drain();

    // 2: period 10, check window length and valid latency.
    sig_per = 10;
    repeat (20) @(posedge clk);
    sb_q.push_back(model(10, 32));
    pulse_start(1'b0);
    busy_cnt = 0; valid_at = 0;
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (valid_o && valid_at == 0) valid_at = k;
    end
    chk("t2_busy_cycles", busy_cnt, 32'd100);
    chk("t2_valid_at", valid_at, 32'd101);
    chk("t2_freq", freq_o, 32'd10);
    chk("t2_ovf", {31'd0, ovf_o}, 32'd0);

    // 4: abort by dropping en mid-window; no report, old result kept.
    pulse_start(1'b0);
    repeat (49) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_busy", {31'd0, busy_o}, 32'd0);
    repeat (150) @(negedge clk);
    chk("t4_freq", freq_o, 32'd10);
    chk("t4_ovf", {31'd0, ovf_o}, 32'd0);
    #1 en = 1'b1;

    // Reset mid-measurement clears outputs on the next edge.
    pulse_start(1'b0);
    repeat (30) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst_mid");
    #1 rst = 1'b0;

    // 5: 4-bit counter saturates at 15, then a slow input reads cleanly.
    sig_per = 4;
    repeat (20) @(posedge clk);
    sb4_q.push_back(model(4, 4));
    pulse_start(1'b1);
    drain();
    sig_per = 20;
    repeat (30) @(posedge clk);
    sb4_q.push_back(model(20, 4));
    pulse_start(1'b1);
    drain();
    chk("t5_freq4", {28'd0, freq4_o}, 32'd5);
    chk("t5_ovf4", {31'd0, ovf4_o}, 32'd0);
`else
    // 6: continuous mode, one report every G+1 cycles while en is high.
    sig_per = 5;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(model(5, 32));
      sb4_q.push_back(model(5, 4));
    end
    #1 en = 1'b1;
    nval = 0; last_cyc = 0;
    for (int k = 0; k < 400 && nval < 3; k++) begin
      @(negedge clk);
      if (valid_o) begin
        if (nval > 0) chk("t6_interval", cyc - last_cyc, G + 1);
        last_cyc = cyc;
        nval++;
      end
    end
    chk("t6_nvalid", nval, 32'd3);
    #1 en = 1'b0;
    repeat (250) @(negedge clk);
    chk("t6_busy_off", {31'd0, busy_o}, 32'd0);
`endif

    chk("sb_left", sb_q.size() + sb4_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
